// File: rtl/dev_ram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dev_ram_arbiter_if
// Purpose  : Request/grant/switch bundle between two RAM requesters and the arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface dev_ram_arbiter_if;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic select;
    logic busy;
    logic preempt;

    modport master (
        output req0,
        output req1,
        input  gnt0,
        input  gnt1,
        input  select,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req0,
        input  req1,
        output gnt0,
        output gnt1,
        output select,
        output busy,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/dev_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dev_ram_arbiter
// Purpose  : Two-way round-robin RAM arbiter with hold limit and switch select.
// Revision : 1.0  initial release
// ============================================================================
module dev_ram_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dev_ram_arbiter_if.slave bus
);

    localparam int                 c_CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MAX_HOLD - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GRANT0 = 2'd1;
    localparam logic [1:0] c_GRANT1 = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_last;
    logic               r_select;
    logic [c_CNT_W-1:0] r_hold_cnt;
    logic               w_hold_done;

    assign w_hold_done = (r_hold_cnt == c_HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_last     <= 1'b1;
            r_select   <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_IDLE) begin
                r_hold_cnt <= '0;
                // select only moves on grant entry, so the switch is stable for the whole grant
                if (w_next_state == c_GRANT0) begin
                    r_last   <= 1'b0;
                    r_select <= 1'b0;
                end else if (w_next_state == c_GRANT1) begin
                    r_last   <= 1'b1;
                    r_select <= 1'b1;
                end
            end else if (!w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_next_state = r_last ? c_GRANT0 : c_GRANT1;
                end else if (bus.req0) begin
                    w_next_state = c_GRANT0;
                end else if (bus.req1) begin
                    w_next_state = c_GRANT1;
                end
            end
            c_GRANT0: begin
                if (!bus.req0 || (bus.req1 && w_hold_done)) begin
                    w_next_state = c_IDLE;
                end
            end
            c_GRANT1: begin
                if (!bus.req1 || (bus.req0 && w_hold_done)) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt0    = (r_state == c_GRANT0);
        bus.gnt1    = (r_state == c_GRANT1);
        bus.busy    = (r_state == c_GRANT0) || (r_state == c_GRANT1);
        bus.select  = r_select;
        // a release in the same cycle wins, hence the own-request term
        bus.preempt = w_hold_done &&
                      (((r_state == c_GRANT0) && bus.req0 && bus.req1) ||
                       ((r_state == c_GRANT1) && bus.req1 && bus.req0));
    end

endmodule
`default_nettype wire

// File: tb/tb_dev_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dev_ram_arbiter
// Purpose  : Directed scenarios plus randomized run against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dev_ram_arbiter;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    dev_ram_arbiter_if bus ();

    dev_ram_arbiter #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_out;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        logic [4:0] obs;
        rst      = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        tick();
        obs = {bus.gnt0, bus.gnt1, bus.select, bus.busy, bus.preempt};
        n_total++;
        if (obs !== 5'b00000)
            $display("FAIL reset_outputs: got %b required 00000 (gnt0,gnt1,select,busy,preempt)", obs);
        else n_pass++;
        rst = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_tie_first;
        logic [2:0] obs;
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        obs = {bus.gnt0, bus.gnt1, bus.select};
        n_total++;
        if (obs !== 3'b100)
            $display("FAIL tie_first: got %b required 100 (gnt0,gnt1,select)", obs);
        else n_pass++;
        idle_out();
    endtask

    task automatic test_single_req1;
        logic [2:0] obs, exp;
        for (int c = 0; c < 6; c++) begin
            bus.req0 = 1'b0;
            bus.req1 = (c < 3);
            tick();
            exp = {1'b0, ((c + 1) <= 3), 1'b1};
            obs = {bus.gnt0, bus.gnt1, bus.select};
            n_total++;
            if (obs !== exp)
                $display("FAIL single_req1 cycle %0d: got %b required %b (gnt0,gnt1,select)", c + 1, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin;
        logic [4:0] obs, exp;
        int p;
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (c == 0) exp = 5'b00000;
            else begin
                p = (c - 1) % 10;
                exp[4] = (p <= 3);
                exp[3] = (p >= 5 && p <= 8);
                exp[2] = exp[3];
                exp[1] = exp[4] | exp[3];
                exp[0] = (p == 3) || (p == 8);
            end
            obs = {bus.gnt0, bus.gnt1, bus.select & bus.busy, bus.busy, bus.preempt};
            n_total++;
            if (obs !== exp)
                $display("FAIL round_robin cycle %0d: got %b required %b (gnt0,gnt1,sel&busy,busy,preempt)", c, obs, exp);
            else n_pass++;
            tick();
        end
        idle_out();
    endtask

    task automatic test_release_priority;
        logic [2:0] obs, exp;
        do_reset();
        bus.req1 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            bus.req0 = (c < 4);
            #1;
            exp = {(c >= 1 && c <= 3), (c >= 6), 1'b0};
            if (c == 4) exp = 3'b100;
            obs = {bus.gnt0, bus.gnt1, bus.preempt};
            n_total++;
            if (obs !== exp)
                $display("FAIL release_priority cycle %0d: got %b required %b (gnt0,gnt1,preempt)", c, obs, exp);
            else n_pass++;
            tick();
        end
        idle_out();
    endtask

    task automatic test_saturate;
        logic [2:0] obs, exp;
        do_reset();
        for (int c = 0; c < 23; c++) begin
            bus.req0 = 1'b1;
            bus.req1 = (c >= 20);
            #1;
            exp = {(c >= 1 && c <= 20), (c >= 22), (c == 20)};
            obs = {bus.gnt0, bus.gnt1, bus.preempt};
            n_total++;
            if (obs !== exp)
                $display("FAIL saturate cycle %0d: got %b required %b (gnt0,gnt1,preempt)", c, obs, exp);
            else n_pass++;
            tick();
        end
        idle_out();
    endtask

    task automatic test_reset_mid_grant;
        logic [3:0] obs;
        do_reset();
        bus.req1 = 1'b1;
        tick();
        tick();
        n_total++;
        if ({bus.gnt1, bus.select} !== 2'b11)
            $display("FAIL mid_grant_setup: got %b required 11 (gnt1,select)", {bus.gnt1, bus.select});
        else n_pass++;
        bus.req0 = 1'b1;
        rst      = 1'b1;
        tick();
        obs = {bus.gnt0, bus.gnt1, bus.select, bus.busy};
        n_total++;
        if (obs !== 4'b0000)
            $display("FAIL mid_grant_reset: got %b required 0000 (gnt0,gnt1,select,busy)", obs);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if ({bus.gnt0, bus.gnt1, bus.select} !== 3'b100)
            $display("FAIL mid_grant_tie: got %b required 100 (gnt0,gnt1,select)", {bus.gnt0, bus.gnt1, bus.select});
        else n_pass++;
        idle_out();
    endtask

    task automatic test_random;
        int         owner, last, run, nfail;
        logic       sel, r0, r1, e_pre;
        logic [4:0] obs, exp;
        logic [1:0] rq;
        do_reset();
        owner = -1; last = 1; run = 0; sel = 1'b0; nfail = 0;
        r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) r0 = ~r0;
            if ($urandom_range(0, 7) == 0) r1 = ~r1;
            bus.req0 = r0;
            bus.req1 = r1;
            #1;
            rq    = {r1, r0};
            e_pre = (owner >= 0) && rq[owner] && rq[1 - owner] && (run >= MH);
            exp   = {owner == 0, owner == 1, sel, owner >= 0, e_pre};
            obs   = {bus.gnt0, bus.gnt1, bus.select, bus.busy, bus.preempt};
            n_total++;
            if (obs !== exp) begin
                nfail++;
                if (nfail <= 10)
                    $display("FAIL random cycle %0d: got %b required %b (gnt0,gnt1,select,busy,preempt)", i, obs, exp);
            end else n_pass++;
            if (owner < 0) begin
                if (r0 && r1) owner = (last == 0) ? 1 : 0;
                else if (r0)  owner = 0;
                else if (r1)  owner = 1;
                if (owner >= 0) begin
                    last = owner;
                    run  = 1;
                    sel  = (owner == 1);
                end
            end else if (!rq[owner] || e_pre) begin
                owner = -1;
            end else begin
                run++;
            end
            tick();
        end
        idle_out();
    endtask

    initial begin
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        test_reset();
        test_tie_first();
        test_single_req1();
        test_round_robin();
        test_release_priority();
        test_saturate();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
